// File: rtl/mcu_rst_pkg.sv
// Shared types and constants for the MCU reset sequencer.
// The reset-cause register is built only when MCU_RST_CAUSE_EN is defined.
package mcu_rst_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_RST = 2'd1,
        SYS_RST = 2'd2,
        HOLDOFF = 2'd3
    } rst_state_e;

    localparam int CAUSE_POR = 0;
    localparam int CAUSE_CPU = 1;
    localparam int CAUSE_SYS = 2;
    localparam int CAUSE_WDT = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Output pattern {pad_cpu_rst_b, pad_had_rst_b, sys_resetn, rst_busy} while in state s
    function automatic logic [3:0] rst_outs(input rst_state_e s);
        logic [3:0] o;
        case (s)
            IDLE:    o = 4'b1110;
            CPU_RST: o = 4'b0111;
            SYS_RST: o = 4'b0001;
            HOLDOFF: o = 4'b1111;
            default: o = 4'b0001;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/mcu_rst_filt.sv
// Request glitch filter: qualifies a level request after FILT_CYC consecutive high samples.
module mcu_rst_filt
    import mcu_rst_pkg::*;
#(
    parameter int FILT_CYC = 2
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic req,
    output logic qual
);

    localparam int FW = $clog2(FILT_CYC + 1);
    localparam logic [FW-1:0] CNT_SAT  = FW'(FILT_CYC);
    localparam logic [FW-1:0] CNT_LAST = FW'(FILT_CYC - 1);

    logic [FW-1:0] cnt_r;

    // Saturating run-length counter of consecutive high samples
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_r <= {FW{1'b0}};
        end else if (req) begin
            if (cnt_r != CNT_SAT) begin
                cnt_r <= cnt_r + FW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            cnt_r <= {FW{1'b0}};
        end
    end

    // Qualified on the edge that brings the run to FILT_CYC, and for as long as it stays high
    assign qual = req && (cnt_r >= CNT_LAST);

endmodule

// File: rtl/mcu_rst_ctrl.sv
// Reset request sequencer for the C902 core/HAD reset pads.
// Define MCU_RST_CAUSE_EN to build the sticky rst_cause register; otherwise rst_cause reads 4'b0000.
module mcu_rst_ctrl
    import mcu_rst_pkg::*;
#(
    parameter int FILT_CYC    = 2,
    parameter int PULSE_CYC   = 8,
    parameter int HOLDOFF_CYC = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [1:0] cpu_pad_soft_rst,
    input  logic       wdt_rst_req,
    input  logic       rst_cause_clr,
    output logic       pad_cpu_rst_b,
    output logic       pad_had_rst_b,
    output logic       sys_resetn,
    output logic       rst_busy,
    output logic [3:0] rst_cause
);

    localparam int CNT_W = $clog2(max_int(PULSE_CYC, HOLDOFF_CYC) + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYC - 1);

    logic             cpu_acc_s;
    logic             sys_acc_s;
    logic             wdt_acc_s;
    logic             sys_any_s;
    rst_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;

    mcu_rst_filt #(.FILT_CYC(FILT_CYC)) u_filt_cpu (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .req     (cpu_pad_soft_rst[0]),
        .qual    (cpu_acc_s)
    );

    mcu_rst_filt #(.FILT_CYC(FILT_CYC)) u_filt_sys (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .req     (cpu_pad_soft_rst[1]),
        .qual    (sys_acc_s)
    );

    mcu_rst_filt #(.FILT_CYC(FILT_CYC)) u_filt_wdt (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .req     (wdt_rst_req),
        .qual    (wdt_acc_s)
    );

    assign sys_any_s = sys_acc_s | wdt_acc_s;

    // Sequencer FSM; pad outputs are registered from the state being entered
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r <= SYS_RST;
            cnt_r   <= CNT_ZERO;
            {pad_cpu_rst_b, pad_had_rst_b, sys_resetn, rst_busy} <= rst_outs(SYS_RST);
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r <= CNT_ZERO;
                    if (sys_any_s) begin
                        state_r <= SYS_RST;
                        {pad_cpu_rst_b, pad_had_rst_b, sys_resetn, rst_busy} <= rst_outs(SYS_RST);
                    end else if (cpu_acc_s) begin
                        state_r <= CPU_RST;
                        {pad_cpu_rst_b, pad_had_rst_b, sys_resetn, rst_busy} <= rst_outs(CPU_RST);
                    end else begin
                        state_r <= IDLE;
                        {pad_cpu_rst_b, pad_had_rst_b, sys_resetn, rst_busy} <= rst_outs(IDLE);
                    end
                end
                CPU_RST: begin
                    if (sys_any_s) begin
                        state_r <= SYS_RST;
                        cnt_r   <= CNT_ZERO;
                        {pad_cpu_rst_b, pad_had_rst_b, sys_resetn, rst_busy} <= rst_outs(SYS_RST);
                    end else if (cnt_r == PULSE_LAST) begin
                        state_r <= HOLDOFF;
                        cnt_r   <= CNT_ZERO;
                        {pad_cpu_rst_b, pad_had_rst_b, sys_resetn, rst_busy} <= rst_outs(HOLDOFF);
                    end else begin
                        state_r <= CPU_RST;
                        cnt_r   <= cnt_r + CNT_W'(1);
                        {pad_cpu_rst_b, pad_had_rst_b, sys_resetn, rst_busy} <= rst_outs(CPU_RST);
                    end
                end
                SYS_RST: begin
                    if (cnt_r == PULSE_LAST) begin
                        state_r <= HOLDOFF;
                        cnt_r   <= CNT_ZERO;
                        {pad_cpu_rst_b, pad_had_rst_b, sys_resetn, rst_busy} <= rst_outs(HOLDOFF);
                    end else begin
                        state_r <= SYS_RST;
                        cnt_r   <= cnt_r + CNT_W'(1);
                        {pad_cpu_rst_b, pad_had_rst_b, sys_resetn, rst_busy} <= rst_outs(SYS_RST);
                    end
                end
                HOLDOFF: begin
                    if (cnt_r == HOLD_LAST) begin
                        state_r <= IDLE;
                        cnt_r   <= CNT_ZERO;
                        {pad_cpu_rst_b, pad_had_rst_b, sys_resetn, rst_busy} <= rst_outs(IDLE);
                    end else begin
                        state_r <= HOLDOFF;
                        cnt_r   <= cnt_r + CNT_W'(1);
                        {pad_cpu_rst_b, pad_had_rst_b, sys_resetn, rst_busy} <= rst_outs(HOLDOFF);
                    end
                end
                default: begin
                    state_r <= SYS_RST;
                    cnt_r   <= CNT_ZERO;
                    {pad_cpu_rst_b, pad_had_rst_b, sys_resetn, rst_busy} <= rst_outs(SYS_RST);
                end
            endcase
        end
    end

`ifdef MCU_RST_CAUSE_EN
    logic [3:0] cause_r;
    logic [3:0] cause_set_s;

    // Cause bits raised by the transition taken this cycle; cpu only counts when it wins
    always_comb begin
        cause_set_s = 4'b0000;
        if ((state_r == IDLE) || (state_r == CPU_RST)) begin
            if (sys_any_s) begin
                cause_set_s[CAUSE_SYS] = sys_acc_s;
                cause_set_s[CAUSE_WDT] = wdt_acc_s;
            end else if (state_r == IDLE) begin
                cause_set_s[CAUSE_CPU] = cpu_acc_s;
            end else begin
                cause_set_s = 4'b0000;
            end
        end else begin
            cause_set_s = 4'b0000;
        end
    end

    // Sticky cause flags; a same-cycle set beats the clear
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cause_r <= 4'b0001;
        end else if (rst_cause_clr) begin
            cause_r <= cause_set_s;
        end else begin
            cause_r <= cause_r | cause_set_s;
        end
    end

    assign rst_cause = cause_r;
`else
    logic unused_cause_clr_s;

    assign unused_cause_clr_s = rst_cause_clr;
    assign rst_cause          = 4'b0000;
`endif

endmodule

// File: tb/tb_mcu_rst_ctrl.sv
// Directed self-checking bench for mcu_rst_ctrl at default parameters.
module tb_mcu_rst_ctrl;

    logic       sys_clk;
    logic       sys_rst;
    logic [1:0] cpu_pad_soft_rst;
    logic       wdt_rst_req;
    logic       rst_cause_clr;
    logic       pad_cpu_rst_b;
    logic       pad_had_rst_b;
    logic       sys_resetn;
    logic       rst_busy;
    logic [3:0] rst_cause;
    logic [3:0] outs;

    int checks = 0;
    int errors = 0;

    mcu_rst_ctrl dut (
        .sys_clk          (sys_clk),
        .sys_rst          (sys_rst),
        .cpu_pad_soft_rst (cpu_pad_soft_rst),
        .wdt_rst_req      (wdt_rst_req),
        .rst_cause_clr    (rst_cause_clr),
        .pad_cpu_rst_b    (pad_cpu_rst_b),
        .pad_had_rst_b    (pad_had_rst_b),
        .sys_resetn       (sys_resetn),
        .rst_busy         (rst_busy),
        .rst_cause        (rst_cause)
    );

    // {pad_cpu_rst_b, pad_had_rst_b, sys_resetn, rst_busy}
    assign outs = {pad_cpu_rst_b, pad_had_rst_b, sys_resetn, rst_busy};

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [3:0] exp_cause(input logic [3:0] v);
`ifdef MCU_RST_CAUSE_EN
        return v;
`else
        return 4'b0000;
`endif
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        sys_rst          = 1'b1;
        cpu_pad_soft_rst = 2'b00;
        wdt_rst_req      = 1'b0;
        rst_cause_clr    = 1'b0;

        // 1. Power-on reset
        tick(3);
        check("por_outs", outs, 4'b0001);
        check("por_cause", rst_cause, exp_cause(4'b0001));
        sys_rst = 1'b0;
        tick(7);
        check("por_pulse_last", outs, 4'b0001);
        tick(1);
        check("por_release", outs, 4'b1111);
        tick(3);
        check("por_holdoff_last", outs, 4'b1111);
        tick(1);
        check("por_idle", outs, 4'b1110);
        check("por_cause_idle", rst_cause, exp_cause(4'b0001));

        // 2. Core request: a 1-cycle blip is filtered, a 2-cycle request is taken
        cpu_pad_soft_rst = 2'b01;
        tick(1);
        cpu_pad_soft_rst = 2'b00;
        tick(1);
        check("cpu_blip", outs, 4'b1110);
        tick(2);
        check("cpu_blip_late", outs, 4'b1110);
        cpu_pad_soft_rst = 2'b01;
        tick(1);
        check("cpu_first_sample", outs, 4'b1110);
        tick(1);
        cpu_pad_soft_rst = 2'b00;
        check("cpu_accept", outs, 4'b0111);
        check("cpu_cause", rst_cause, exp_cause(4'b0011));
        tick(7);
        check("cpu_pulse_last", outs, 4'b0111);
        tick(1);
        check("cpu_release", outs, 4'b1111);
        tick(4);
        check("cpu_idle", outs, 4'b1110);

        // 3. Escalation: wdt raised in the 3rd CPU_RST cycle
        cpu_pad_soft_rst = 2'b01;
        tick(2);
        cpu_pad_soft_rst = 2'b00;
        check("esc_cpu_entry", outs, 4'b0111);
        tick(2);
        wdt_rst_req = 1'b1;
        tick(1);
        check("esc_cpu_4th", outs, 4'b0111);
        tick(1);
        wdt_rst_req = 1'b0;
        check("esc_sys_entry", outs, 4'b0001);
        check("esc_cause", rst_cause, exp_cause(4'b1011));
        tick(7);
        check("esc_pulse_last", outs, 4'b0001);
        tick(1);
        check("esc_release", outs, 4'b1111);
        tick(4);
        check("esc_idle", outs, 4'b1110);

        // 4. Simultaneous core+system request held high
        cpu_pad_soft_rst = 2'b11;
        tick(1);
        check("sim_first_sample", outs, 4'b1110);
        tick(1);
        check("sim_sys_wins", outs, 4'b0001);
        check("sim_cause", rst_cause, exp_cause(4'b1111));
        tick(8);
        check("sim_release", outs, 4'b1111);
        tick(3);
        check("sim_holdoff_masked", outs, 4'b1111);
        tick(1);
        check("sim_idle", outs, 4'b1110);
        tick(1);
        check("sim_reaccept", outs, 4'b0001);
        cpu_pad_soft_rst = 2'b00;
        tick(12);
        check("sim_idle2", outs, 4'b1110);

        // 5. Clear on the same edge as a wdt acceptance
        wdt_rst_req = 1'b1;
        tick(1);
        rst_cause_clr = 1'b1;
        tick(1);
        rst_cause_clr = 1'b0;
        wdt_rst_req   = 1'b0;
        check("clr_set_outs", outs, 4'b0001);
        check("clr_set_cause", rst_cause, exp_cause(4'b1000));
        tick(12);
        check("clr_idle", outs, 4'b1110);
        check("clr_cause_kept", rst_cause, exp_cause(4'b1000));

        // 6. sys_rst in the 5th SYS_RST cycle, together with a clear pulse
        cpu_pad_soft_rst = 2'b10;
        tick(2);
        cpu_pad_soft_rst = 2'b00;
        check("mid_sys_entry", outs, 4'b0001);
        check("mid_cause_pre", rst_cause, exp_cause(4'b1100));
        tick(4);
        sys_rst       = 1'b1;
        rst_cause_clr = 1'b1;
        tick(1);
        sys_rst       = 1'b0;
        rst_cause_clr = 1'b0;
        check("mid_reset_outs", outs, 4'b0001);
        check("mid_reset_cause", rst_cause, exp_cause(4'b0001));
        tick(7);
        check("mid_pulse_last", outs, 4'b0001);
        tick(1);
        check("mid_release", outs, 4'b1111);
        tick(4);
        check("mid_idle", outs, 4'b1110);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
